// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the scanned 7-segment display slice:
//   - state_t / IDLE, CONVERT, DONE : conversion FSM encoding
//   - SEG_BLANK, SEG_DASH           : special segment patterns (g..a, active-low)
//   - BCD_DIGITS                    : nibble count produced by the BCD engine
//   - bcd_to_seg()                  : BCD nibble to active-low g..a pattern
// ---------------------------------------------------------------------------
package seg_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE    = 2'd0;
    localparam state_t CONVERT = 2'd1;
    localparam state_t DONE    = 2'd2;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // 2^32-1 has ten decimal digits, so ten BCD nibbles cover any input
    localparam int BCD_DIGITS = 10;

    // Non-decimal nibbles fall back to blank rather than a garbage glyph
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
        logic [6:0] code;
        case (nibble)
            4'd0:    code = 7'b1000000;
            4'd1:    code = 7'b1111001;
            4'd2:    code = 7'b0100100;
            4'd3:    code = 7'b0110000;
            4'd4:    code = 7'b0011001;
            4'd5:    code = 7'b0010010;
            4'd6:    code = 7'b0000010;
            4'd7:    code = 7'b1111000;
            4'd8:    code = 7'b0000000;
            4'd9:    code = 7'b0010000;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
// Sequential double-dabble converter: one add-3/shift step per clock,
// 32 steps per conversion.
// Ports:
//   clk    in   1   system clock, rising edge
//   reset  in   1   synchronous, active-high; aborts any conversion
//   start  in   1   load bin into the shift register on this edge
//   bin    in   32  binary value, sampled only when start is high
//   bcd    out  40  ten BCD nibbles, final once the last step has executed
//   done   out  1   high during the cycle whose closing edge does step 32
// ---------------------------------------------------------------------------
module bin2bcd_seq
    import seg_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] bin,
    output logic [39:0] bcd,
    output logic        done
);

    localparam int SR_W = 4 * BCD_DIGITS + 32;

    logic [SR_W-1:0] shift_q;
    logic [SR_W-1:0] adjusted;
    logic [4:0]      step_q;
    logic            running_q;

    // Add 3 to every BCD nibble that is 5 or more, ahead of the shift
    always_comb begin
        adjusted = shift_q;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (shift_q[32 + 4*i +: 4] >= 4'd5) begin
                adjusted[32 + 4*i +: 4] = shift_q[32 + 4*i +: 4] + 4'd3;
            end
        end
    end

    // Load on start, then 32 adjust/shift steps; step 31 is the final one
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q   <= '0;
            step_q    <= '0;
            running_q <= 1'b0;
        end else if (start) begin
            shift_q   <= {{(4*BCD_DIGITS){1'b0}}, bin};
            step_q    <= '0;
            running_q <= 1'b1;
        end else if (running_q) begin
            shift_q <= {adjusted[SR_W-2:0], 1'b0};
            step_q  <= step_q + 5'd1;
            if (step_q == 5'd31) begin
                running_q <= 1'b0;
            end
        end
    end

    // Early indication lets the parent leave CONVERT on the same edge that
    // completes the last shift, so bcd is already final in DONE
    assign done = running_q && (step_q == 5'd31);
    assign bcd  = shift_q[SR_W-1:32];

endmodule

// File: rtl/seg_scan_display.sv
// ---------------------------------------------------------------------------
// seg_scan_display
// Converts a 32-bit binary count to BCD and time-multiplexes it onto an
// 8-digit active-low 7-segment display. The display image only changes
// atomically when a conversion completes.
// Ports:
//   clk       in   1       system clock, rising edge
//   reset     in   1       synchronous, active-high
//   number    in   32      value to show; sampled only while idle
//   scan_cnt  in   SCAN_W  clk cycles per digit slot (0 behaves as 1)
//   seg       out  8       active-low segments, [7]=dp (always off), [6:0]=g..a
//   an        out  DIGITS  active-low one-hot digit enable, an[0]=LS digit
//   busy      out  1       conversion in flight
// Build option: define LEADING_ZERO_BLANK_EN to blank digits above the most
// significant non-zero digit (digit 0 is always shown).
// ---------------------------------------------------------------------------
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int DIGITS = 8,
    parameter int SCAN_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       number,
    input  logic [SCAN_W-1:0] scan_cnt,
    output logic [7:0]        seg,
    output logic [DIGITS-1:0] an,
    output logic              busy
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_t              state_q;
    logic [31:0]         shadow_q;
    logic [4*DIGITS-1:0] disp_q;
    logic                ovf_q;
    logic                busy_q;
    logic [SCAN_W-1:0]   presc_q;
    logic [IDX_W-1:0]    idx_q;
    logic [7:0]          seg_q;
    logic [DIGITS-1:0]   an_q;

    logic                start;
    logic [39:0]         bcd;
    logic                bcd_done;
    logic [SCAN_W-1:0]   scan_limit;
    logic                terminal;
    logic [3:0]          cur_nibble;
    logic                blank_cur;
    logic [6:0]          digit_code;
    logic [DIGITS-1:0]   an_next;

    // A new conversion is requested only from IDLE and only on a real change
    assign start = (state_q == IDLE) && (number != shadow_q);

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (number),
        .bcd   (bcd),
        .done  (bcd_done)
    );

    // Conversion FSM; the display register is only written in DONE so the
    // scanned image never shows a half-converted value
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            disp_q   <= '0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        shadow_q <= number;
                        busy_q   <= 1'b1;
                        state_q  <= CONVERT;
                    end
                end
                CONVERT: begin
                    if (bcd_done) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    disp_q  <= bcd[4*DIGITS-1:0];
                    ovf_q   <= |bcd[39:4*DIGITS];
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Using >= means a shrunk scan_cnt fires the terminal action on the next
    // edge instead of letting the prescaler run all the way around
    assign scan_limit = (scan_cnt == '0) ? SCAN_W'(1) : scan_cnt;
    assign terminal   = (presc_q >= (scan_limit - SCAN_W'(1)));

    // Digit-slot prescaler and scan index
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            idx_q   <= '0;
        end else if (terminal) begin
            presc_q <= '0;
            idx_q   <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end else begin
            presc_q <= presc_q + SCAN_W'(1);
        end
    end

    assign cur_nibble = disp_q[{idx_q, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] zero_above;

    // zero_above[g]: digit g and every digit above it are zero
    for (genvar g = 0; g < DIGITS; g++) begin : g_zero_above
        assign zero_above[g] = (disp_q[4*DIGITS-1:4*g] == '0);
    end

    assign blank_cur = zero_above[idx_q] && (idx_q != '0);
`else
    assign blank_cur = 1'b0;
`endif

    // Overflow dashes take priority over both the digit and blanking
    always_comb begin
        digit_code = bcd_to_seg(cur_nibble);
        if (ovf_q) begin
            digit_code = SEG_DASH;
        end else if (blank_cur) begin
            digit_code = SEG_BLANK;
        end
    end

    assign an_next = ~(DIGITS'(1) << idx_q);

    // seg and an registered together so the pattern and enable never skew
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q <= 8'hFF;
            an_q  <= '1;
        end else begin
            seg_q <= {1'b1, digit_code};
            an_q  <= an_next;
        end
    end

    assign seg  = seg_q;
    assign an   = an_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_display
// Self-checking bench for seg_scan_display. Expected display values are
// queued when a number is driven and popped once the conversion finishes;
// the scanned seg/an pattern is predicted from decimal arithmetic and an
// independent model of the digit-slot timing.
// ---------------------------------------------------------------------------
module tb_seg_scan_display;

    localparam int DIGITS = 8;
    localparam int SCAN_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [31:0]       number;
    logic [SCAN_W-1:0] scan_cnt;
    logic [7:0]        seg;
    logic [DIGITS-1:0] an;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

    typedef struct {
        logic [31:0] num;
        int          sc;
        logic [6:0]  d0;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    seg_scan_display #(
        .DIGITS (DIGITS),
        .SCAN_W (SCAN_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .number   (number),
        .scan_cnt (scan_cnt),
        .seg      (seg),
        .an       (an),
        .busy     (busy)
    );

    // Scan-timing model: which digit slot the registered outputs show
    int m_pre       = 0;
    int m_idx       = 0;
    int m_out_idx   = 0;
    bit m_out_valid = 1'b0;

    always @(posedge clk) begin
        int lim;
        if (reset) begin
            m_pre       = 0;
            m_idx       = 0;
            m_out_valid = 1'b0;
        end else begin
            lim         = (scan_cnt == 0) ? 1 : int'(scan_cnt);
            m_out_idx   = m_idx;
            m_out_valid = 1'b1;
            if (m_pre >= lim - 1) begin
                m_pre = 0;
                m_idx = (m_idx + 1) % DIGITS;
            end else begin
                m_pre++;
            end
        end
    end

    // Expected g..a pattern for one digit position of a value
    function automatic logic [6:0] exp_code(input logic [31:0] val, input int pos);
        longint v = longint'(val);
        longint p = 1;
        int     digit;
        for (int k = 0; k < pos; k++) p = p * 10;
        if (v > 64'd99999999) return 7'b0111111;
        digit = int'((v / p) % 10);
`ifdef LEADING_ZERO_BLANK_EN
        if (pos != 0 && (v / p) == 0) return 7'b1111111;
`endif
        return seg_tab[digit];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] num, input int sc, input bit push);
        @(negedge clk);
        number   = num;
        scan_cnt = SCAN_W'(sc);
        if (push) exp_q.push_back(num);
    endtask

    // Wait for a conversion to start, then measure how long busy stays high
    task automatic waitConversion(input string name);
        int t   = 0;
        int len = 0;
        while (busy !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        checkOutput({name, "_busy_rise"}, 32'(busy), 32'd1);
        while (busy === 1'b1 && len < 60) begin
            @(negedge clk);
            len++;
        end
        checkOutput({name, "_busy_len"}, 32'(len), 32'd33);
    endtask

    // Pop the expected value and compare the scanned outputs over a window
    task automatic checkDisplay(input string name, input int window,
                                input logic [6:0] d0);
        logic [31:0] val;
        logic [7:0]  onehot;
        logic [7:0]  exp_an;
        logic [7:0]  exp_seg;
        bit          d0_seen = 1'b0;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL %s_queue actual=empty required=entry", name);
            return;
        end
        val = exp_q.pop_front();
        @(posedge clk);
        for (int w = 0; w < window; w++) begin
            @(negedge clk);
            onehot  = 8'd1 << m_out_idx;
            exp_an  = m_out_valid ? ~onehot : 8'hFF;
            exp_seg = m_out_valid ? {1'b1, exp_code(val, m_out_idx)} : 8'hFF;
            checkOutput({name, "_an"}, 32'(an), 32'(exp_an));
            checkOutput($sformatf("%s_seg_d%0d", name, m_out_idx), 32'(seg), 32'(exp_seg));
            if (!d0_seen && m_out_valid && m_out_idx == 0) begin
                checkOutput({name, "_digit0"}, 32'(seg[6:0]), 32'(d0));
                d0_seen = 1'b1;
            end
        end
        if (!d0_seen) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s_digit0 actual=unseen required=%b", name, d0);
        end
    endtask

    // Hard stop so a stuck DUT can never hang the run
    initial begin
        #1000000;
        failures++;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int t;
        int len;

        vecs[0] = '{num: 32'd12345678,  sc: 4, d0: 7'b0000000};
        vecs[1] = '{num: 32'd100000000, sc: 2, d0: 7'b0111111};
        vecs[2] = '{num: 32'd99999999,  sc: 3, d0: 7'b0010000};
        vecs[3] = '{num: 32'd42,        sc: 1, d0: 7'b0100100};
        vecs[4] = '{num: 32'd0,         sc: 0, d0: 7'b1000000};
        vecs[5] = '{num: 32'd3054,      sc: 5, d0: 7'b0011001};
        vecs[6] = '{num: 32'd70000001,  sc: 2, d0: 7'b1111001};
        vecs[7] = '{num: 32'hFFFFFFFF,  sc: 1, d0: 7'b0111111};

        reset    = 1'b1;
        number   = 32'd0;
        scan_cnt = SCAN_W'(4);

        // Reset held for three edges
        repeat (3) begin
            @(negedge clk);
            checkOutput("reset_seg",  32'(seg),  32'hFF);
            checkOutput("reset_an",   32'(an),   32'hFF);
            checkOutput("reset_busy", 32'(busy), 32'd0);
        end
        reset = 1'b0;

        // number=0 matches the cleared shadow, so no conversion starts
        exp_q.push_back(32'd0);
        checkDisplay("post_reset", 2 * DIGITS * 4 + 2, 7'b1000000);
        checkOutput("post_reset_busy", 32'(busy), 32'd0);

        // Table-driven conversions across scan rates and value boundaries
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].num, vecs[i].sc, 1'b1);
            waitConversion($sformatf("vec%0d", i));
            checkDisplay($sformatf("vec%0d", i),
                         2 * DIGITS * ((vecs[i].sc == 0) ? 1 : vecs[i].sc) + 2,
                         vecs[i].d0);
        end

        // number changes 5 -> 6 ten edges into the conversion of 5
        applyStimulus(32'd5, 1, 1'b1);
        t = 0;
        while (busy !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        checkOutput("toggle_busy_rise", 32'(busy), 32'd1);
        len = 0;
        repeat (9) begin
            @(negedge clk);
            len++;
        end
        number = 32'd6;
        exp_q.push_back(32'd6);
        while (busy === 1'b1 && len < 60) begin
            @(negedge clk);
            len++;
        end
        checkOutput("toggle_busy_len", 32'(len), 32'd33);
        checkDisplay("toggle_first", 12, 7'b0010010);
        checkOutput("toggle_rearm", 32'(busy), 32'd1);
        t = 0;
        while (busy === 1'b1 && t < 60) begin
            @(negedge clk);
            t++;
        end
        checkOutput("toggle_second_done", 32'(busy), 32'd0);
        checkDisplay("toggle_second", 12, 7'b0000010);

        // Reset in the middle of a conversion aborts it and clears the image
        applyStimulus(32'd777, 3, 1'b0);
        t = 0;
        while (busy !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        checkOutput("abort_busy_rise", 32'(busy), 32'd1);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_seg",  32'(seg),  32'hFF);
        checkOutput("abort_an",   32'(an),   32'hFF);
        number = 32'd0;
        reset  = 1'b0;
        exp_q.push_back(32'd0);
        checkDisplay("after_abort", 2 * DIGITS * 3 + 2, 7'b1000000);
        checkOutput("after_abort_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
